// File: rtl/nibble_rx_pkg.sv
// Shared types and constants for the nibble link receiver.
// Included by nibble_rx and available to the other lane-group receivers.
package nibble_rx_pkg;

   localparam int NIB_W  = 4;
   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RECV = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/nibble_rx_fifo.sv
// Registered first-word-fall-through sync FIFO.
// The head entry is visible whenever valid is high. A pushed byte becomes
// visible one cycle after the push, even if the FIFO was empty.
// A push while full is accepted only if a pop happens in the same cycle.
module nibble_rx_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   input  logic             pop,
   output logic             valid,
   output logic [WIDTH-1:0] dout
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CNT_W-1:0] count;
   logic             wr_en;
   logic             rd_en;

   assign full  = (count == CNT_W'(DEPTH));
   assign valid = (count != '0);
   assign rd_en = pop & valid;
   assign wr_en = push & (~full | rd_en);
   assign dout  = valid ? mem[rd_ptr] : '0;

   // Pointer and occupancy update; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care while the entry is unoccupied.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/nibble_rx.sv
// Receive end of the 4-lane nibble link: input registers, frame FSM,
// nibble-to-byte packer (low nibble first), frame status and byte FIFO.
// Optional build macro PATTERN_CHECK_EN adds a checker for the generator's
// free-running 4-bit counter pattern; without it pattern_err is tied low.
//
// state | meaning
// IDLE  | waiting for a rising edge of the frame flag with enable high
// RECV  | consuming one nibble per cycle while the frame flag is high
// DONE  | one-cycle end of frame: publish length/odd status, clear packer
module nibble_rx
   import nibble_rx_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int LEN_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic [NIB_W-1:0]  rxd_i,
   input  logic              rxf_i,
   output logic [BYTE_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic              frame_done,
   output logic [LEN_W-1:0]  frame_len,
   output logic              err_odd,
   output logic              overflow,
   output logic              pattern_err
);

   logic [NIB_W-1:0]  rxd_q;
   logic              rxf_q;
   logic              rxf_qq;
   logic              start;
   state_t            state;
   state_t            state_nxt;
   logic              consume;
   logic              phase;
   logic [NIB_W-1:0]  low_nib;
   logic [LEN_W-1:0]  byte_cnt;
   logic              push;
   logic              pop;
   logic              full;
   logic [BYTE_W-1:0] byte_in;

   // Pin registers. The flag history resets high so a frame that is already
   // running when reset releases never looks like a rising edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         rxd_q  <= '0;
         rxf_q  <= 1'b1;
         rxf_qq <= 1'b1;
      end else begin
         rxd_q  <= rxd_i;
         rxf_q  <= rxf_i;
         rxf_qq <= rxf_q;
      end
   end

   assign start = rxf_q & ~rxf_qq;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next state and per-cycle controls; the start cycle already carries nibble 0.
   always_comb begin
      state_nxt  = state;
      consume    = 1'b0;
      frame_done = 1'b0;
      case (state)
         IDLE: begin
            if (start & enable) begin
               state_nxt = RECV;
               consume   = 1'b1;
            end
         end
         RECV: begin
            if (rxf_q) consume   = 1'b1;
            else       state_nxt = DONE;
         end
         DONE: begin
            frame_done = 1'b1;
            state_nxt  = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign push    = consume & phase;
   assign byte_in = {rxd_q, low_nib};
   assign pop     = dout_valid & dout_ready;

   // Packer, saturating byte counter, frame status and sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase     <= 1'b0;
         low_nib   <= '0;
         byte_cnt  <= '0;
         frame_len <= '0;
         err_odd   <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (frame_done) begin
            frame_len <= byte_cnt;
            err_odd   <= phase;
            phase     <= 1'b0;
            byte_cnt  <= '0;
         end else if (consume) begin
            phase <= ~phase;
            if (!phase)
               low_nib <= rxd_q;
            else if (byte_cnt != '1)
               byte_cnt <= byte_cnt + 1'b1;
         end
         if (push & full & ~pop) overflow <= 1'b1;
      end
   end

   nibble_rx_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (BYTE_W)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (byte_in),
      .full  (full),
      .pop   (pop),
      .valid (dout_valid),
      .dout  (dout)
   );

`ifdef PATTERN_CHECK_EN
   logic [NIB_W-1:0] exp_nib;

   // Counter-pattern checker. The next expected value is always the received
   // nibble plus one: on a match that equals exp+1, on a mismatch it re-seeds.
   // Nibble 0 is the only one consumed from IDLE and is never compared.
   always_ff @(posedge clk) begin
      if (rst) begin
         exp_nib     <= '0;
         pattern_err <= 1'b0;
      end else if (consume) begin
         exp_nib <= rxd_q + 4'd1;
         if ((state != IDLE) && (rxd_q != exp_nib)) pattern_err <= 1'b1;
      end
   end
`else
   assign pattern_err = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_rx.sv
// Self-checking bench for nibble_rx: directed frames followed by random
// frames, checked against a frame-level reference model.
module tb_nibble_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [3:0]  rxd_i;
   logic        rxf_i;
   logic [7:0]  dout;
   logic        dout_valid;
   logic        dout_ready;
   logic        frame_done;
   logic [15:0] frame_len;
   logic        err_odd;
   logic        overflow;
   logic        pattern_err;

   int          ncmp = 0;
   int          nfail = 0;
   int          ndone = 0;
   int          d0;
   logic [7:0]  got[$];
   logic [3:0]  frame_q[$];
   logic [7:0]  exp_bytes[$];
   int          exp_len;
   bit          exp_odd;
   bit          exp_pat = 1'b0;

   nibble_rx #(.DEPTH(16), .LEN_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .rxd_i       (rxd_i),
      .rxf_i       (rxf_i),
      .dout        (dout),
      .dout_valid  (dout_valid),
      .dout_ready  (dout_ready),
      .frame_done  (frame_done),
      .frame_len   (frame_len),
      .err_odd     (err_odd),
      .overflow    (overflow),
      .pattern_err (pattern_err)
   );

   always #5 clk = ~clk;

   // Output monitor: record accepted bytes and frame_done pulses.
   always @(negedge clk) begin
      if (dout_valid && dout_ready) got.push_back(dout);
      if (frame_done) ndone++;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Frame-level reference: pair nibbles low-first, count bytes, odd flag,
   // and track whether the stream broke the +1 counter pattern.
   task automatic model_frame;
      logic [3:0] nx;
      exp_len = frame_q.size() / 2;
      exp_odd = frame_q.size() % 2;
      for (int i = 0; i + 1 < frame_q.size(); i += 2)
         exp_bytes.push_back({frame_q[i+1], frame_q[i]});
      for (int i = 1; i < frame_q.size(); i++) begin
         nx = frame_q[i-1] + 4'd1;
         if (frame_q[i] != nx) exp_pat = 1'b1;
      end
   endtask

   // rdy_mode: 0 keep dout_ready, 1 hold it high, 2 random during frame.
   task automatic send_frame(input int rdy_mode);
      for (int i = 0; i < frame_q.size(); i++) begin
         rxf_i = 1'b1;
         rxd_i = frame_q[i];
         if (rdy_mode == 1)      dout_ready = 1'b1;
         else if (rdy_mode == 2) dout_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      rxf_i = 1'b0;
      rxd_i = 4'h0;
      if (rdy_mode != 0) dout_ready = 1'b1;
      repeat (24) tick();
   endtask

   task automatic check_frame(input string tag, input int exp_ndone, input bit exp_ovf);
      bit pat;
`ifdef PATTERN_CHECK_EN
      pat = exp_pat;
`else
      pat = 1'b0;
`endif
      chk($sformatf("%s frame_len", tag), 32'(frame_len), 32'(exp_len));
      chk($sformatf("%s err_odd", tag), 32'(err_odd), 32'(exp_odd));
      chk($sformatf("%s ndone", tag), 32'(ndone), 32'(exp_ndone));
      chk($sformatf("%s nbytes", tag), 32'(got.size()), 32'(exp_bytes.size()));
      for (int i = 0; i < exp_bytes.size(); i++)
         chk($sformatf("%s byte%0d", tag, i),
             (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_bytes[i]));
      chk($sformatf("%s overflow", tag), 32'(overflow), 32'(exp_ovf));
      chk($sformatf("%s pattern_err", tag), 32'(pattern_err), 32'(pat));
      got.delete();
      exp_bytes.delete();
   endtask

   task automatic chk_all_zero(input string tag);
      chk($sformatf("%s dout_valid", tag), 32'(dout_valid), 32'd0);
      chk($sformatf("%s dout", tag), 32'(dout), 32'd0);
      chk($sformatf("%s frame_done", tag), 32'(frame_done), 32'd0);
      chk($sformatf("%s frame_len", tag), 32'(frame_len), 32'd0);
      chk($sformatf("%s err_odd", tag), 32'(err_odd), 32'd0);
      chk($sformatf("%s overflow", tag), 32'(overflow), 32'd0);
      chk($sformatf("%s pattern_err", tag), 32'(pattern_err), 32'd0);
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; rxd_i = 4'h0; rxf_i = 1'b0; dout_ready = 1'b0;
      repeat (3) tick();
      chk_all_zero("reset");
      rst = 1'b0; enable = 1'b1; dout_ready = 1'b1;
      repeat (3) tick();

      // Test 1: nibbles 1,2,3,4 with cycle-exact latency checks.
      frame_q = '{4'h1, 4'h2, 4'h3, 4'h4};
      model_frame();
      rxf_i = 1'b1; rxd_i = 4'h1;
      chk("t1 idle valid", 32'(dout_valid), 32'd0);
      tick(); rxd_i = 4'h2;
      tick(); rxd_i = 4'h3;
      tick(); rxd_i = 4'h4;
      chk("t1 valid0", 32'(dout_valid), 32'd1);
      chk("t1 dout0", 32'(dout), 32'h21);
      tick(); rxf_i = 1'b0; rxd_i = 4'h0;
      chk("t1 gap valid", 32'(dout_valid), 32'd0);
      tick();
      chk("t1 valid1", 32'(dout_valid), 32'd1);
      chk("t1 dout1", 32'(dout), 32'h43);
      tick();
      chk("t1 done pulse", 32'(frame_done), 32'd1);
      tick();
      chk("t1 done low", 32'(frame_done), 32'd0);
      repeat (20) tick();
      check_frame("t1", 1, 1'b0);

      // Test 2: odd frame A,B,C; trailing C discarded.
      frame_q = '{4'hA, 4'hB, 4'hC};
      model_frame();
      send_frame(1);
      check_frame("t2", 2, 1'b0);

      // Test 3: 36-nibble frame with consumer stalled -> overflow.
      frame_q.delete();
      for (int i = 0; i < 36; i++) frame_q.push_back(4'(i));
      model_frame();
      dout_ready = 1'b0;
      send_frame(0);
      chk("t3 frame_len", 32'(frame_len), 32'd18);
      chk("t3 err_odd", 32'(err_odd), 32'd0);
      chk("t3 ndone", 32'(ndone), 32'd3);
      chk("t3 overflow", 32'(overflow), 32'd1);
      chk("t3 held valid", 32'(dout_valid), 32'd1);
      chk("t3 none popped", 32'(got.size()), 32'd0);
      dout_ready = 1'b1;
      repeat (20) tick();
      chk("t3 drained", 32'(got.size()), 32'd16);
      for (int i = 0; i < 16; i++)
         chk($sformatf("t3 byte%0d", i),
             (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp_bytes[i]));
      chk("t3 overflow sticky", 32'(overflow), 32'd1);
      got.delete();
      exp_bytes.delete();

      // Test 4: enable low at frame start, raised mid-frame -> frame ignored.
      d0 = ndone;
      enable = 1'b0;
      for (int i = 0; i < 8; i++) begin
         rxf_i = 1'b1;
         rxd_i = 4'($urandom_range(0, 15));
         if (i == 2) enable = 1'b1;
         tick();
      end
      rxf_i = 1'b0; rxd_i = 4'h0;
      repeat (24) tick();
      chk("t4 no bytes", 32'(got.size()), 32'd0);
      chk("t4 no done", 32'(ndone), 32'(d0));
      chk("t4 len held", 32'(frame_len), 32'd18);
      frame_q = '{4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hA};
      model_frame();
      send_frame(1);
      check_frame("t4", d0 + 1, 1'b1);

      // Test 5: reset after 5 nibbles of a 10-nibble frame.
      for (int i = 0; i < 5; i++) begin
         rxf_i = 1'b1; rxd_i = 4'(i);
         tick();
      end
      rxd_i = 4'h5; rst = 1'b1;
      tick();
      chk_all_zero("t5 rst");
      rst = 1'b0;
      exp_pat = 1'b0;
      got.delete();
      d0 = ndone;
      for (int i = 6; i < 10; i++) begin
         rxf_i = 1'b1; rxd_i = 4'(i);
         tick();
      end
      rxf_i = 1'b0; rxd_i = 4'h0;
      repeat (24) tick();
      chk("t5 ignored bytes", 32'(got.size()), 32'd0);
      chk("t5 ignored done", 32'(ndone), 32'(d0));
      frame_q = '{4'h0, 4'h1, 4'h2, 4'h3};
      model_frame();
      send_frame(1);
      check_frame("t5", d0 + 1, 1'b0);

      // Test 6: counter pattern with wrap, then a break, then clean again.
      frame_q = '{4'hE, 4'hF, 4'h0, 4'h1};
      model_frame();
      send_frame(1);
      check_frame("t6 wrap", d0 + 2, 1'b0);
      frame_q = '{4'h3, 4'h4, 4'h6};
      model_frame();
      send_frame(1);
      check_frame("t6 break", d0 + 3, 1'b0);
      frame_q = '{4'h7, 4'h8, 4'h9, 4'hA};
      model_frame();
      send_frame(1);
      check_frame("t6 sticky", d0 + 4, 1'b0);

      // Random frames with random consumer stalls; FIFO starts each frame empty.
      d0 = ndone;
      for (int f = 0; f < 12; f++) begin
         int len;
         len = $urandom_range(1, 24);
         frame_q.delete();
         for (int i = 0; i < len; i++) frame_q.push_back(4'($urandom_range(0, 15)));
         model_frame();
         send_frame(2);
         check_frame($sformatf("rnd%0d", f), d0 + f + 1, 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
